// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds op codes, default latencies, FSM state and result bundle types.
package md_unit_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'd0;
  localparam md_op_t MD_MULTU = 3'd1;
  localparam md_op_t MD_DIV   = 3'd2;
  localparam md_op_t MD_DIVU  = 3'd3;
  localparam md_op_t MD_MTHI  = 3'd4;
  localparam md_op_t MD_MTLO  = 3'd5;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } md_state_t;

  // ok=0 means the op finishes but must not touch HI/LO.
  typedef struct packed {
    logic        ok;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic is_mul(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between EX stage and the MD unit.
// master: EX stage drives start/md_op/A/B; slave: md_unit returns busy/hi/lo.
interface md_unit_if;
  import md_unit_pkg::*;

  logic        start;
  md_op_t      md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, A, B,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, A, B,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_unit_calc.sv
// Combinational 64-bit multiply/divide result from (md_op, a, b).
// Ports: md_op, a, b in; res out (res.ok=0 on divide by zero).
module md_unit_calc
  import md_unit_pkg::*;
(
  input  md_op_t      md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] sq_u;
  logic        [31:0] sr_u;
  logic        [31:0] b_safe;
  logic        [31:0] uq;
  logic        [31:0] ur;

  assign prod_s = $signed({{32{a[31]}}, a})
                * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes: avoids the
  // 0x80000000 / -1 overflow corner entirely.
  assign a_neg = a[31];
  assign b_neg = b[31];
  assign mag_a = a_neg ? (32'd0 - a) : a;
  assign mag_b = b_neg ? (32'd0 - b) : b;

  // Keep the dividers X-free when b==0.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;

  logic [31:0] mag_b_safe;
  assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;

  assign sq_u = mag_a / mag_b_safe;
  assign sr_u = mag_a % mag_b_safe;
  assign uq   = a / b_safe;
  assign ur   = a % b_safe;

  always_comb begin
    res = '0;
    unique case (1'b1)
      (md_op == MD_MULT): begin
        res.ok = 1'b1;
        res.hi = prod_s[63:32];
        res.lo = prod_s[31:0];
      end
      (md_op == MD_MULTU): begin
        res.ok = 1'b1;
        res.hi = prod_u[63:32];
        res.lo = prod_u[31:0];
      end
      (md_op == MD_DIV): begin
        res.ok = (b != 32'd0);
        res.lo = (a_neg ^ b_neg) ? (32'd0 - sq_u) : sq_u;
        res.hi = a_neg ? (32'd0 - sr_u) : sr_u;
      end
      (md_op == MD_DIVU): begin
        res.ok = (b != 32'd0);
        res.lo = uq;
        res.hi = ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO with a busy counter.
// Ports: clk, reset (async active-low), md (slave: start/md_op/A/B in, busy/hi/lo out).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES)
                       ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_res_t          res_q, res_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  md_res_t          calc_res;

  md_unit_calc u_calc (
    .md_op (md.md_op),
    .a     (md.A),
    .b     (md.B),
    .res   (calc_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (md.start) begin
          unique case (1'b1)
            is_mul(md.md_op): begin
              state_d = S_RUN;
              cnt_d   = CNT_W'(MULT_CYCLES);
              res_d   = calc_res;
            end
            is_div(md.md_op): begin
              state_d = S_RUN;
              cnt_d   = CNT_W'(DIV_CYCLES);
              res_d   = calc_res;
            end
            (md.md_op == MD_MTHI): hi_d = md.A;
            (md.md_op == MD_MTLO): lo_d = md.A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // start is ignored here; upstream stall holds it off.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (res_q.ok) begin
            hi_d = res_q.hi;
            lo_d = res_q.lo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign md.busy = (state_q == S_RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
